// File: rtl/hash_pkg.sv
// hash_pkg: shared types for the hash-table operation sequencer.
//   op_t        : request opcode carried in the top two bits of a stream word
//   status_t    : response status carried in the top two bits of a response word
//   seq_state_t : sequencer FSM states
//   entry_t     : one table slot as stored in the entry RAM {used, key, value}
package hash_pkg;

  localparam int unsigned HASH_KEY_W   = 14;
  localparam int unsigned HASH_VALUE_W = 16;
  localparam int unsigned HASH_ADDR_W  = 8;
  localparam int unsigned HASH_STAT_W  = 16;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_MISS = 2'b01,
    ST_COLL = 2'b10,
    ST_NOP  = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_EVAL   = 3'd3,
    S_COMMIT = 3'd4,
    S_RESP   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic                    used;
    logic [HASH_KEY_W-1:0]   key;
    logic [HASH_VALUE_W-1:0] value;
  } entry_t;

  // Saturating increment for the statistics counters.
  function automatic logic [HASH_STAT_W-1:0] sat_inc(input logic [HASH_STAT_W-1:0] v);
    return (v == {HASH_STAT_W{1'b1}}) ? v : v + HASH_STAT_W'(1);
  endfunction

endpackage

// File: rtl/hash_index_fold.sv
// hash_index_fold: combinational XOR-fold of a key into a table index.
// The key is split into ADDR_WIDTH-bit chunks starting at the LSB; the last
// chunk is zero-padded, and all chunks are XORed together.
// Ports:
//   i_key   in  KEY_WIDTH   key to fold
//   o_index out ADDR_WIDTH  folded slot index
module hash_index_fold #(
  parameter int unsigned KEY_WIDTH  = 14,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic [KEY_WIDTH-1:0]  i_key,
  output logic [ADDR_WIDTH-1:0] o_index
);

  localparam int unsigned NCHUNK = (KEY_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;
  localparam int unsigned PAD_W  = NCHUNK * ADDR_WIDTH;

  logic [PAD_W-1:0] w_padded;

  always_comb begin
    w_padded = PAD_W'(i_key);
    o_index  = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      o_index = o_index ^ w_padded[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

endmodule

// File: rtl/hash_op_sequencer.sv
// hash_op_sequencer: runs one hash-table operation at a time from the input
// stream against a single-port entry RAM and returns one response word per op.
// Optional build macro: HASH_SEQ_STATS_EN adds saturating hit/miss/collision
// counters (stat_hits, stat_misses, stat_collisions).
// KEY_WIDTH/VALUE_WIDTH must match the entry_t widths in hash_pkg.
// Response value field: READ hit -> stored value; WRITE (OK or COLLISION) ->
// request value; NOP -> request value; MISS and DELETE -> zero.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   data_in/valid_i/last_i/keep_i/ready_o   request stream {op, value, key}
//   read_data_o/valid_o/last_o/keep_o/ready_i response stream {status, value, key}
//   mem_addr/mem_rd_en/mem_rdata/mem_wr_en/mem_wdata  entry RAM port
//   stat_hits/stat_misses/stat_collisions   (HASH_SEQ_STATS_EN only)
module hash_op_sequencer
  import hash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEY_WIDTH   = HASH_KEY_W,
  parameter int unsigned VALUE_WIDTH = HASH_VALUE_W,
  parameter int unsigned ADDR_WIDTH  = HASH_ADDR_W,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              valid_i,
  input  logic                              last_i,
  input  logic [7:0]                        keep_i,
  output logic                              ready_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              last_o,
  output logic [7:0]                        keep_o,
  output logic [DATA_WIDTH-1:0]             read_data_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_rd_en,
  input  logic [1+KEY_WIDTH+VALUE_WIDTH-1:0] mem_rdata,
  output logic                              mem_wr_en,
  output logic [1+KEY_WIDTH+VALUE_WIDTH-1:0] mem_wdata
`ifdef HASH_SEQ_STATS_EN
  ,
  output logic [HASH_STAT_W-1:0]            stat_hits,
  output logic [HASH_STAT_W-1:0]            stat_misses,
  output logic [HASH_STAT_W-1:0]            stat_collisions
`endif
);

  localparam int unsigned CNT_W = 3;

  seq_state_t              r_state;
  op_t                     r_op;
  logic [KEY_WIDTH-1:0]    r_key;
  logic [VALUE_WIDTH-1:0]  r_value;
  logic                    r_ready;
  logic                    r_valid;
  logic                    r_last;
  logic [7:0]              r_keep;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd_en;
  logic                    r_wr_en;
  entry_t                  r_wdata;
  entry_t                  r_entry;
  logic [CNT_W-1:0]        r_wait_cnt;

  op_t                     w_op;
  logic [KEY_WIDTH-1:0]    w_key;
  logic [VALUE_WIDTH-1:0]  w_value;
  logic [ADDR_WIDTH-1:0]   w_index;
  logic                    w_hit;

  assign w_op    = op_t'(data_in[DATA_WIDTH-1 -: 2]);
  assign w_key   = data_in[KEY_WIDTH-1:0];
  assign w_value = data_in[DATA_WIDTH-3:KEY_WIDTH];
  assign w_hit   = r_entry.used && (r_entry.key == r_key);

  hash_index_fold #(
    .KEY_WIDTH (KEY_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fold (
    .i_key  (w_key),
    .o_index(w_index)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_key      <= '0;
      r_value    <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_keep     <= '0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wdata    <= '0;
      r_entry    <= '0;
      r_wait_cnt <= '0;
    end else begin
      // Memory strobes are single-cycle pulses.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && valid_i) begin
            r_ready <= 1'b0;
            r_op    <= w_op;
            r_key   <= w_key;
            r_value <= w_value;
            r_last  <= last_i;
            r_keep  <= keep_i;
            if (w_op == OP_NOP) begin
              r_rdata <= {ST_NOP, w_value, w_key};
              r_valid <= 1'b1;
              r_state <= S_RESP;
            end else begin
              // Strobe rises with ISSUE; address stays put until the next op.
              r_addr  <= w_index;
              r_rd_en <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= CNT_W'(MEM_LATENCY - 1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // Capture the slot on the exact cycle it is valid.
          if (r_wait_cnt == '0) begin
            r_entry <= entry_t'(mem_rdata);
            r_state <= S_EVAL;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_EVAL: begin
          r_valid <= 1'b1;
          r_state <= S_RESP;
          case (r_op)
            OP_READ: begin
              if (w_hit) r_rdata <= {ST_OK, r_entry.value, r_key};
              else       r_rdata <= {ST_MISS, {VALUE_WIDTH{1'b0}}, r_key};
            end
            OP_WRITE: begin
              if (w_hit || !r_entry.used) begin
                r_rdata <= {ST_OK, r_value, r_key};
                r_wdata <= entry_t'{used: 1'b1, key: r_key, value: r_value};
                r_wr_en <= 1'b1;
                r_valid <= 1'b0;
                r_state <= S_COMMIT;
              end else begin
                r_rdata <= {ST_COLL, r_value, r_key};
              end
            end
            OP_DELETE: begin
              if (w_hit) begin
                r_rdata <= {ST_OK, {VALUE_WIDTH{1'b0}}, r_key};
                r_wdata <= entry_t'{used: 1'b0, key: r_key, value: '0};
                r_wr_en <= 1'b1;
                r_valid <= 1'b0;
                r_state <= S_COMMIT;
              end else begin
                r_rdata <= {ST_MISS, {VALUE_WIDTH{1'b0}}, r_key};
              end
            end
            default: r_rdata <= {ST_NOP, r_value, r_key};
          endcase
        end
        S_COMMIT: begin
          r_valid <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign last_o      = r_last;
  assign keep_o      = r_keep;
  assign read_data_o = r_rdata;
  assign mem_addr    = r_addr;
  assign mem_rd_en   = r_rd_en;
  assign mem_wr_en   = r_wr_en;
  assign mem_wdata   = r_wdata;

`ifdef HASH_SEQ_STATS_EN
  logic [HASH_STAT_W-1:0] r_stat_hits;
  logic [HASH_STAT_W-1:0] r_stat_misses;
  logic [HASH_STAT_W-1:0] r_stat_coll;

  // Outcome counters, sampled once per op in EVAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_coll   <= '0;
    end else if (r_state == S_EVAL) begin
      if (w_hit) r_stat_hits <= sat_inc(r_stat_hits);
      if (!w_hit && (r_op == OP_READ || r_op == OP_DELETE))
        r_stat_misses <= sat_inc(r_stat_misses);
      if (r_op == OP_WRITE && r_entry.used && !w_hit)
        r_stat_coll <= sat_inc(r_stat_coll);
    end
  end

  assign stat_hits       = r_stat_hits;
  assign stat_misses     = r_stat_misses;
  assign stat_collisions = r_stat_coll;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_hash_op_sequencer.sv
// Bench for hash_op_sequencer: directed cases then random ops, checked against
// a table model indexed by a bit-wise key fold. Includes a RAM model with
// MEM_LATENCY read pipeline.
module tb_hash_op_sequencer;

  localparam int unsigned LAT = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned KW  = 14;
  localparam int unsigned VW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned EW  = 1 + KW + VW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_i;
  logic          last_i;
  logic [7:0]    keep_i;
  logic          ready_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic [7:0]    keep_o;
  logic [DW-1:0] read_data_o;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [EW-1:0] mem_rdata;
  logic          mem_wr_en;
  logic [EW-1:0] mem_wdata;
`ifdef HASH_SEQ_STATS_EN
  logic [15:0]   stat_hits;
  logic [15:0]   stat_misses;
  logic [15:0]   stat_collisions;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hash_op_sequencer #(
    .DATA_WIDTH (DW),
    .KEY_WIDTH  (KW),
    .VALUE_WIDTH(VW),
    .ADDR_WIDTH (AW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .keep_i     (keep_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .keep_o     (keep_o),
    .read_data_o(read_data_o),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata)
`ifdef HASH_SEQ_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses),
    .stat_collisions(stat_collisions)
`endif
  );

  // Entry RAM with a LAT-deep read pipeline.
  logic          tb_clear;
  logic [EW-1:0] tb_mem [256];
  logic [EW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
      for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (mem_rd_en) rd_pipe[0] <= tb_mem[mem_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference table state.
  bit          ref_used [256];
  logic [13:0] ref_key  [256];
  logic [15:0] ref_val  [256];

  function automatic logic [7:0] ref_fold(input logic [13:0] k);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 14; b++) r[b % 8] = r[b % 8] ^ k[b];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one op from a negedge, returns at the negedge after the response handshake.
  task automatic run_op(input logic [1:0] op, input logic [13:0] key,
                        input logic [15:0] val, input int hold);
    logic [7:0]  idx;
    logic [1:0]  exp_st;
    logic [15:0] exp_v;
    bit          exp_wr;
    logic [30:0] exp_wd;
    int          exp_lat;
    logic        l;
    logic [7:0]  kp;
    bit          acc;
    bit          got;
    int          k;
    int          rd_cnt;
    int          wr_cnt;
    int          wr_at;
    logic [7:0]  rd_addr;
    logic [7:0]  wr_addr;
    logic [30:0] wd_seen;
    logic [31:0] held;

    idx = ref_fold(key);
    l   = 1'($urandom);
    kp  = 8'($urandom);
    exp_wr = 1'b0; exp_wd = '0; exp_v = '0; exp_st = 2'd0;
    exp_lat = 3 + LAT;
    case (op)
      2'd0: begin exp_st = 2'd3; exp_v = val; exp_lat = 1; end
      2'd1: begin
        if (ref_used[idx] && ref_key[idx] == key) begin exp_st = 2'd0; exp_v = ref_val[idx]; end
        else exp_st = 2'd1;
      end
      2'd2: begin
        exp_v = val;
        if (!ref_used[idx] || ref_key[idx] == key) begin
          exp_st = 2'd0; exp_wr = 1'b1; exp_wd = {1'b1, key, val}; exp_lat = 4 + LAT;
          ref_used[idx] = 1'b1; ref_key[idx] = key; ref_val[idx] = val;
        end else exp_st = 2'd2;
      end
      default: begin
        if (ref_used[idx] && ref_key[idx] == key) begin
          exp_st = 2'd0; exp_wr = 1'b1; exp_wd = {1'b0, key, 16'h0000}; exp_lat = 4 + LAT;
          ref_used[idx] = 1'b0;
        end else exp_st = 2'd1;
      end
    endcase

    data_in = {op, val, key}; valid_i = 1'b1; last_i = l; keep_i = kp; ready_i = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      if (ready_o) acc = 1'b1;
      else @(negedge clk);
    end
    check("accept", 64'(acc), 64'd1);
    @(posedge clk);

    got = 1'b0; k = 0; rd_cnt = 0; wr_cnt = 0; wr_at = 0;
    rd_addr = '0; wr_addr = '0; wd_seen = '0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin valid_i = 1'b0; data_in = $urandom; end
      if (mem_rd_en) begin rd_cnt++; rd_addr = mem_addr; end
      if (mem_wr_en) begin wr_cnt++; wr_at = k; wr_addr = mem_addr; wd_seen = mem_wdata; end
      if (valid_o) got = 1'b1;
    end
    check("resp_timeout", 64'(got), 64'd1);
    check("latency", 64'(k), 64'(exp_lat));
    check("read_data", 64'(read_data_o), 64'({exp_st, exp_v, key}));
    check("last_keep", 64'({last_o, keep_o}), 64'({l, kp}));
    check("rd_count", 64'(rd_cnt), (op == 2'd0) ? 64'd0 : 64'd1);
    if (op != 2'd0) check("rd_addr", 64'(rd_addr), 64'(idx));
    check("wr_count", 64'(wr_cnt), 64'(exp_wr));
    if (exp_wr) begin
      check("wr_cycle", 64'(wr_at), 64'(3 + LAT));
      check("wr_addr", 64'(wr_addr), 64'(idx));
      check("wr_data", 64'(wd_seen), 64'(exp_wd));
    end

    held = read_data_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_state", 64'({valid_o, ready_o, mem_wr_en}), 64'(3'b100));
      check("hold_data", 64'({read_data_o, last_o, keep_o}), 64'({held, l, kp}));
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("after_resp", 64'({valid_o, ready_o}), 64'(2'b01));
  endtask

  // WRITE that is reset while waiting on the RAM; must leave no trace.
  task automatic abort_write(input logic [13:0] key, input logic [15:0] val);
    bit acc;
    int wr_seen;
    acc = 1'b0; wr_seen = 0;
    data_in = {2'b10, val, key}; valid_i = 1'b1; ready_i = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      if (ready_o) acc = 1'b1;
      else @(negedge clk);
    end
    check("abort_accept", 64'(acc), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_op", 64'({ready_o, valid_o, last_o, keep_o, read_data_o,
                               mem_addr, mem_rd_en, mem_wr_en}), 64'd0);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_wr_en) wr_seen++;
    end
    check("abort_no_write", 64'(wr_seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tb_clear = 1'b1;
    data_in = '0; valid_i = 1'b0; last_i = 1'b0; keep_i = '0; ready_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_used[i] = 1'b0; ref_key[i] = '0; ref_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ready_o, valid_o, last_o, keep_o, read_data_o,
                                mem_addr, mem_rd_en, mem_wr_en}), 64'd0);
    reset = 1'b0; tb_clear = 1'b0;
    @(negedge clk);

    run_op(2'd0, 14'h1234, 16'h0000, 0);
    run_op(2'd2, 14'h0055, 16'hBEEF, 0);
    run_op(2'd1, 14'h0055, 16'h0000, 0);
    run_op(2'd1, 14'h0077, 16'h0000, 0);
    run_op(2'd2, 14'h0001, 16'h1111, 0);
    run_op(2'd2, 14'h0100, 16'h2222, 0);
    run_op(2'd1, 14'h0001, 16'h0000, 1);
    run_op(2'd3, 14'h0001, 16'h0000, 0);
    run_op(2'd1, 14'h0001, 16'h0000, 0);
    run_op(2'd3, 14'h0001, 16'h0000, 0);
    run_op(2'd1, 14'h0055, 16'h0000, 5);

    abort_write(14'h0200, 16'h3333);
    run_op(2'd1, 14'h0200, 16'h0000, 0);
    run_op(2'd1, 14'h0055, 16'h0000, 0);

    for (int n = 0; n < 80; n++) begin
      run_op(2'($urandom_range(0, 3)),
             14'($urandom_range(0, 7)) | (14'($urandom_range(0, 3)) << 8),
             16'($urandom), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
